// File: rtl/alu_pkg.sv
// Shared definitions for the sequential shifter.
// Holds the operation encodings carried on the Modo port and the
// state encoding of the shifter control FSM.
package alu_pkg;

  typedef enum logic [1:0] {
    MODO_SL  = 2'b00,
    MODO_SR  = 2'b01,
    MODO_ROL = 2'b10,
    MODO_ROR = 2'b11
  } modo_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } estado_t;

endpackage

// File: rtl/desplazador_secuencial_paso.sv
// Single-bit shift/rotate step, purely combinational.
// Ports:
//   data        operand
//   Modo        operation (SL, SR logical, ROL, ROR)
//   desplazado  operand moved by exactly one bit position
module paso_desplazamiento
  import alu_pkg::*;
#(
  parameter int ANCHO = 8
) (
  input  logic [ANCHO-1:0] data,
  input  logic [1:0]       Modo,
  output logic [ANCHO-1:0] desplazado
);

  always_comb begin
    desplazado = data;
    case (modo_t'(Modo))
      MODO_SL:  desplazado = {data[ANCHO-2:0], 1'b0};
      MODO_SR:  desplazado = {1'b0, data[ANCHO-1:1]};
      MODO_ROL: desplazado = {data[ANCHO-2:0], data[ANCHO-1]};
      MODO_ROR: desplazado = {data[0], data[ANCHO-1:1]};
      default:  desplazado = data;
    endcase
  end

endmodule

// File: rtl/desplazador_secuencial.sv
// Sequential shifter: accepts one request in IDLE, moves the operand one bit
// per cycle for Cantidad cycles, then presents the result until consumed.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request handshake (ready only in IDLE)
//   Desplazar, Cantidad    operand and shift amount
//   Modo                   00 SL, 01 SR, 10 ROL, 11 ROR
//   out_valid / out_ready  result handshake (valid only in DONE)
//   Desplazados            data register, visible at all times
//   ocupado                high whenever not IDLE
module desplazador_secuencial
  import alu_pkg::*;
#(
  parameter int ANCHO  = 8,
  parameter int CANT_W = $clog2(ANCHO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ANCHO-1:0]  Desplazar,
  input  logic [CANT_W-1:0] Cantidad,
  input  logic [1:0]        Modo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ANCHO-1:0]  Desplazados,
  output logic              ocupado
);

  estado_t           estado_q, estado_d;
  logic [ANCHO-1:0]  dato_q, dato_d;
  modo_t             modo_q, modo_d;
  logic [CANT_W-1:0] cnt_q, cnt_d;
  logic [ANCHO-1:0]  dato_paso;

  paso_desplazamiento #(
    .ANCHO(ANCHO)
  ) u_paso (
    .data      (dato_q),
    .Modo      (modo_q),
    .desplazado(dato_paso)
  );

  always_comb begin
    estado_d = estado_q;
    dato_d   = dato_q;
    modo_d   = modo_q;
    cnt_d    = cnt_q;
    case (estado_q)
      IDLE: begin
        if (in_valid) begin
          dato_d   = Desplazar;
          modo_d   = modo_t'(Modo);
          cnt_d    = Cantidad;
          estado_d = (Cantidad == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        dato_d = dato_paso;
        cnt_d  = cnt_q - CANT_W'(1);
        if (cnt_q == CANT_W'(1)) estado_d = DONE;
      end
      DONE: begin
        if (out_ready) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      dato_q   <= '0;
      modo_q   <= MODO_SL;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      dato_q   <= dato_d;
      modo_q   <= modo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready    = (estado_q == IDLE);
  assign out_valid   = (estado_q == DONE);
  assign ocupado     = (estado_q != IDLE);
  assign Desplazados = dato_q;

endmodule

// File: doc/desplazador_secuencial.md
DESPLAZADOR_SECUENCIAL -- requirements
Module: desplazador_secuencial

Interface
REQ-001 SHALL have parameter: ANCHO, 8, data width in bits (power of two, >= 2).
REQ-002 SHALL have parameter: CANT_W, $clog2(ANCHO), width of the shift-amount field.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: in_valid  input  1  request present.
REQ-006 SHALL have port: in_ready  output  1  block can accept a request.
REQ-007 SHALL have port: Desplazar  input  ANCHO  operand to shift.
REQ-008 SHALL have port: Cantidad  input  CANT_W  shift amount, 0..ANCHO-1.
REQ-009 SHALL have port: Modo  input  2  operation: 00 SL, 01 SR logical, 10 ROL, 11 ROR.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes result.
REQ-012 SHALL have port: Desplazados  output  ANCHO  shifted result.
REQ-013 SHALL have port: ocupado  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; request accepted on the cycle in_valid && in_ready.
REQ-016 On accept, SHALL register Desplazar, Modo and Cantidad into a data register, mode register and down-counter; inputs are ignored afterwards.
REQ-017 On accept with Cantidad!=0, SHALL go to SHIFT; with Cantidad==0, SHALL go directly to DONE with the operand unchanged.
REQ-018 In SHIFT, SHALL shift the data register by exactly one bit per cycle per Modo and decrement the counter; SL and SR fill with 0; ROL/ROR wrap the outgoing bit.
REQ-019 SHALL leave SHIFT for DONE on the cycle the counter decrements from 1 to 0.
REQ-020 out_valid SHALL rise exactly Cantidad+1 cycles after the accept edge (latency 1 for Cantidad=0).
REQ-021 In DONE, SHALL hold out_valid=1 and Desplazados stable until out_ready=1; on that edge SHALL return to IDLE.
REQ-022 out_valid SHALL be 0 outside DONE; Desplazados SHALL show the data register at all times.
REQ-023 in_valid asserted while not in IDLE SHALL have no effect; no queuing.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 With rst=1 at a clock edge, SHALL enter IDLE and clear the data register, mode register and counter to 0, from any state including mid-SHIFT or DONE; the in-flight result is discarded.
REQ-026 After reset: in_ready=1, out_valid=0, ocupado=0, Desplazados=0.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 SHALL place Modo encodings (MODO_SL, MODO_SR, MODO_ROL, MODO_ROR) and the FSM state encoding in a shared package, alu_pkg.
REQ-029 SHALL implement the single-bit step as a combinational sub-module paso_desplazamiento (inputs: data, Modo; output: data shifted by one), instantiated once.

Verification
REQ-030 SHALL verify: SL, 0xB5, Cantidad=3, out_ready=1 -> out_valid 4 cycles after accept, Desplazados=0xA8.
REQ-031 SHALL verify: SR, 0xB5, Cantidad=7 -> Desplazados=0x01 after 8 cycles; ROR 0xB5 by 7 -> 0x6B.
REQ-032 SHALL verify: ROL, 0x81, Cantidad=1 -> 0x03 after 2 cycles; Cantidad=0 with 0x5A, any Modo -> 0x5A after 1 cycle.
REQ-033 SHALL verify backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, Desplazados held, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 SHALL verify reset mid-SHIFT: rst=1 on the 2nd SHIFT cycle of SL 0xFF by 6 -> next cycle in_ready=1, out_valid=0, Desplazados=0x00; no stale result emitted.
